// File: rtl/l2_cache_ctrl.sv
// l2_cache_ctrl: controller for a set-associative L2 cache with write-back,
// write-allocate policy and round-robin victim selection.
//
// Ports
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   cpu_req_*                    CPU request handshake (valid/ready, rw, addr)
//   cpu_res_valid_o/hit_o        one-cycle response strobe and hit flag
//   tag_index_o, tag_cmp_o       set index and lookup tag of the captured request
//   tag_we_o, tag_w*_o, way_o    tag-memory write port; way_o is the selected way
//   tag_hit_i .. tag_full_i      tag-memory lookup results for the current set
//   mem_req_*, mem_ack_i         line writeback / refill requests to next level
//
// Optional feature: define L2_CTRL_STATS_EN to add 32-bit saturating hit/miss
// counters on stat_hit_o / stat_miss_o.

module l2_cache_ctrl #(
  parameter int unsigned INDEXW  = 10,
  parameter int unsigned OFFSETW = 4,
  parameter int unsigned WAYS    = 8,
  localparam int unsigned TAGW   = 32 - INDEXW - OFFSETW
) (
  input  logic              clk_i,
  input  logic              rst_i,
  // CPU side
  input  logic              cpu_req_valid_i,
  output logic              cpu_req_ready_o,
  input  logic              cpu_req_rw_i,
  input  logic [31:0]       cpu_req_addr_i,
  output logic              cpu_res_valid_o,
  output logic              cpu_res_hit_o,
  // Tag memory side
  output logic [INDEXW-1:0] tag_index_o,
  output logic [TAGW-1:0]   tag_cmp_o,
  output logic              tag_we_o,
  output logic              tag_wvalid_o,
  output logic              tag_wdirty_o,
  output logic [TAGW-1:0]   tag_wtag_o,
  output logic [2:0]        way_o,
  input  logic              tag_hit_i,
  input  logic [2:0]        tag_hit_way_i,
  input  logic              tag_rd_valid_i,
  input  logic              tag_rd_dirty_i,
  input  logic [TAGW-1:0]   tag_rd_tag_i,
  input  logic              tag_full_i,
`ifdef L2_CTRL_STATS_EN
  output logic [31:0]       stat_hit_o,
  output logic [31:0]       stat_miss_o,
`endif
  // Memory side
  output logic              mem_req_valid_o,
  output logic              mem_req_rw_o,
  output logic [31:0]       mem_req_addr_o,
  input  logic              mem_ack_i
);

  localparam logic [2:0] LastWay = 3'(WAYS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StCompare,
    StWriteback,
    StAllocate,
    StResp
  } state_e;

  state_e            r_state, w_state_next;
  logic [TAGW-1:0]   r_tag;
  logic [INDEXW-1:0] r_index;
  logic              r_rw;
  logic [2:0]        r_ptr;
  logic [2:0]        r_vic_way;
  logic [TAGW-1:0]   r_vic_tag;
  logic              r_vic_valid;
  logic              r_vic_dirty;

  logic w_capture, w_latch_victim, w_alloc_done;

  // Victim choice is purely round-robin, so set occupancy and the offset bits
  // of the request address play no part in the control flow.
  logic w_unused;
  assign w_unused = tag_full_i ^ (^cpu_req_addr_i[OFFSETW-1:0]) ^ r_vic_valid ^ r_vic_dirty;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_tag       <= '0;
      r_index     <= '0;
      r_rw        <= 1'b0;
      r_ptr       <= '0;
      r_vic_way   <= '0;
      r_vic_tag   <= '0;
      r_vic_valid <= 1'b0;
      r_vic_dirty <= 1'b0;
    end else begin
      if (w_capture) begin
        r_tag   <= cpu_req_addr_i[31 -: TAGW];
        r_index <= cpu_req_addr_i[OFFSETW +: INDEXW];
        r_rw    <= cpu_req_rw_i;
      end
      if (w_latch_victim) begin
        r_vic_way   <= r_ptr;
        r_vic_tag   <= tag_rd_tag_i;
        r_vic_valid <= tag_rd_valid_i;
        r_vic_dirty <= tag_rd_dirty_i;
      end
      if (w_alloc_done) begin
        r_ptr <= (r_ptr == LastWay) ? 3'd0 : r_ptr + 3'd1;
      end
    end
  end

  // Ready is masked by reset so nothing can be accepted while rst_i is held.
  assign cpu_req_ready_o = (r_state == StIdle) && !rst_i;
  assign tag_index_o     = r_index;
  assign tag_cmp_o       = r_tag;

  always_comb begin
    w_state_next    = r_state;
    w_capture       = 1'b0;
    w_latch_victim  = 1'b0;
    w_alloc_done    = 1'b0;
    cpu_res_valid_o = 1'b0;
    cpu_res_hit_o   = 1'b0;
    tag_we_o        = 1'b0;
    tag_wvalid_o    = 1'b0;
    tag_wdirty_o    = 1'b0;
    tag_wtag_o      = '0;
    way_o           = r_vic_way;
    mem_req_valid_o = 1'b0;
    mem_req_rw_o    = 1'b0;
    mem_req_addr_o  = '0;
    unique case (r_state)
      StIdle: begin
        if (cpu_req_valid_i) begin
          w_capture    = 1'b1;
          w_state_next = StCompare;
        end
      end
      StCompare: begin
        way_o = r_ptr;
        if (tag_hit_i) begin
          cpu_res_valid_o = 1'b1;
          cpu_res_hit_o   = 1'b1;
          w_state_next    = StIdle;
          if (r_rw) begin
            // Write hit: mark the hitting line dirty in place.
            tag_we_o     = 1'b1;
            way_o        = tag_hit_way_i;
            tag_wvalid_o = 1'b1;
            tag_wdirty_o = 1'b1;
            tag_wtag_o   = r_tag;
          end
        end else begin
          w_latch_victim = 1'b1;
          w_state_next   = (tag_rd_valid_i && tag_rd_dirty_i) ? StWriteback : StAllocate;
        end
      end
      StWriteback: begin
        mem_req_valid_o = 1'b1;
        mem_req_rw_o    = 1'b1;
        mem_req_addr_o  = {r_vic_tag, r_index, {OFFSETW{1'b0}}};
        if (mem_ack_i) begin
          w_state_next = StAllocate;
        end
      end
      StAllocate: begin
        mem_req_valid_o = 1'b1;
        mem_req_addr_o  = {r_tag, r_index, {OFFSETW{1'b0}}};
        if (mem_ack_i) begin
          tag_we_o     = 1'b1;
          tag_wvalid_o = 1'b1;
          tag_wdirty_o = r_rw;
          tag_wtag_o   = r_tag;
          w_alloc_done = 1'b1;
          w_state_next = StResp;
        end
      end
      StResp: begin
        cpu_res_valid_o = 1'b1;
        w_state_next    = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

`ifdef L2_CTRL_STATS_EN
  logic [31:0] r_stat_hit, r_stat_miss;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_stat_hit  <= '0;
      r_stat_miss <= '0;
    end else if (r_state == StCompare) begin
      if (tag_hit_i) begin
        if (r_stat_hit != '1) r_stat_hit <= r_stat_hit + 32'd1;
      end else begin
        if (r_stat_miss != '1) r_stat_miss <= r_stat_miss + 32'd1;
      end
    end
  end

  assign stat_hit_o  = r_stat_hit;
  assign stat_miss_o = r_stat_miss;
`endif

endmodule

// File: tb/tb_l2_cache_ctrl.sv
// Testbench for l2_cache_ctrl: directed scenarios followed by randomized
// requests. Expected responses, memory requests and tag writes are queued by
// the stimulus side from a transaction-level model; a monitor pops and checks.

module tb_l2_cache_ctrl;
  localparam int INDEXW  = 10;
  localparam int OFFSETW = 4;
  localparam int TAGW    = 32 - INDEXW - OFFSETW;

  logic              clk = 1'b0;
  logic              rst;
  logic              cpu_req_valid_i, cpu_req_ready_o, cpu_req_rw_i;
  logic [31:0]       cpu_req_addr_i;
  logic              cpu_res_valid_o, cpu_res_hit_o;
  logic [INDEXW-1:0] tag_index_o;
  logic [TAGW-1:0]   tag_cmp_o, tag_wtag_o, tag_rd_tag_i;
  logic              tag_we_o, tag_wvalid_o, tag_wdirty_o;
  logic [2:0]        way_o, tag_hit_way_i;
  logic              tag_hit_i, tag_rd_valid_i, tag_rd_dirty_i, tag_full_i;
  logic              mem_req_valid_o, mem_req_rw_o, mem_ack_i;
  logic [31:0]       mem_req_addr_o;
`ifdef L2_CTRL_STATS_EN
  logic [31:0]       stat_hit_o, stat_miss_o;
`endif

  l2_cache_ctrl dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .cpu_req_valid_i(cpu_req_valid_i),
    .cpu_req_ready_o(cpu_req_ready_o),
    .cpu_req_rw_i   (cpu_req_rw_i),
    .cpu_req_addr_i (cpu_req_addr_i),
    .cpu_res_valid_o(cpu_res_valid_o),
    .cpu_res_hit_o  (cpu_res_hit_o),
    .tag_index_o    (tag_index_o),
    .tag_cmp_o      (tag_cmp_o),
    .tag_we_o       (tag_we_o),
    .tag_wvalid_o   (tag_wvalid_o),
    .tag_wdirty_o   (tag_wdirty_o),
    .tag_wtag_o     (tag_wtag_o),
    .way_o          (way_o),
    .tag_hit_i      (tag_hit_i),
    .tag_hit_way_i  (tag_hit_way_i),
    .tag_rd_valid_i (tag_rd_valid_i),
    .tag_rd_dirty_i (tag_rd_dirty_i),
    .tag_rd_tag_i   (tag_rd_tag_i),
    .tag_full_i     (tag_full_i),
`ifdef L2_CTRL_STATS_EN
    .stat_hit_o     (stat_hit_o),
    .stat_miss_o    (stat_miss_o),
`endif
    .mem_req_valid_o(mem_req_valid_o),
    .mem_req_rw_o   (mem_req_rw_o),
    .mem_req_addr_o (mem_req_addr_o),
    .mem_ack_i      (mem_ack_i)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic hit; int cyc; } resp_t;
  typedef struct { logic rw; logic [31:0] addr; } mem_t;
  typedef struct { logic [2:0] way; logic dirty; logic [TAGW-1:0] tag; logic [INDEXW-1:0] idx; } tagw_t;

  resp_t q_resp[$];
  mem_t  q_mem[$];
  tagw_t q_tagw[$];

  int   n_checks = 0;
  int   n_pass   = 0;
  int   m_ptr    = 0;  // model round-robin pointer
  int   m_hits   = 0;
  int   m_miss   = 0;
  logic ack_en   = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: every observed DUT output event must match the head of its queue.
  always @(negedge clk) begin
    resp_t r;
    mem_t  m;
    tagw_t t;
    if (!rst) begin
      if (cpu_res_valid_o) begin
        chk("resp_expected", q_resp.size() != 0, 1'b1);
        if (q_resp.size() != 0) begin
          r = q_resp.pop_front();
          chk("resp_hit", cpu_res_hit_o, r.hit);
          if (r.cyc >= 0) chk("hit_latency", cyc, r.cyc);
        end
      end
      if (tag_we_o) begin
        chk("tagw_expected", q_tagw.size() != 0, 1'b1);
        if (q_tagw.size() != 0) begin
          t = q_tagw.pop_front();
          chk("tagw_way", way_o, t.way);
          chk("tagw_valid", tag_wvalid_o, 1'b1);
          chk("tagw_dirty", tag_wdirty_o, t.dirty);
          chk("tagw_tag", tag_wtag_o, t.tag);
          chk("tagw_index", tag_index_o, t.idx);
        end
      end
      if (mem_req_valid_o && mem_ack_i) begin
        chk("mem_expected", q_mem.size() != 0, 1'b1);
        if (q_mem.size() != 0) begin
          m = q_mem.pop_front();
          chk("mem_rw", mem_req_rw_o, m.rw);
          chk("mem_addr", mem_req_addr_o, m.addr);
        end
      end
    end
  end

  // Memory responder: random-latency single-cycle acks, plus stray acks while
  // no request is outstanding.
  initial begin
    mem_ack_i = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_ack_i) mem_ack_i = 1'b0;
      else if (mem_req_valid_o) mem_ack_i = ack_en && ($urandom % 3 == 0);
      else mem_ack_i = ($urandom % 6 == 0);
    end
  end

  function automatic int pending();
    return q_resp.size() + q_mem.size() + q_tagw.size();
  endfunction

  task automatic txn(input logic [31:0] addr, input logic rw, input logic hit,
                     input logic [2:0] hway, input logic vv, input logic vd,
                     input logic [TAGW-1:0] vtag, input logic wait_done);
    logic [TAGW-1:0]   tag;
    logic [INDEXW-1:0] idx;
    int n;
    int p0;
    tag = addr[31 -: TAGW];
    idx = addr[OFFSETW +: INDEXW];
    @(negedge clk);
    cpu_req_valid_i = 1'b1;
    cpu_req_rw_i    = rw;
    cpu_req_addr_i  = addr;
    tag_hit_i       = hit;
    tag_hit_way_i   = hway;
    tag_rd_valid_i  = vv;
    tag_rd_dirty_i  = vd;
    tag_rd_tag_i    = vtag;
    tag_full_i      = 1'($urandom);
    n = 0;
    while (!cpu_req_ready_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", n < 100, 1'b1);
    // Accepted at the coming edge; queue what this request must produce.
    p0 = m_ptr;
    if (hit) begin
      m_hits++;
      q_resp.push_back('{1'b1, cyc + 1});
      if (rw) q_tagw.push_back('{hway, 1'b1, tag, idx});
    end else begin
      m_miss++;
      if (vv && vd) q_mem.push_back('{1'b1, {vtag, idx, 4'h0}});
      q_mem.push_back('{1'b0, {tag, idx, 4'h0}});
      q_tagw.push_back('{3'(m_ptr), rw, tag, idx});
      m_ptr = (m_ptr + 1) % 8;
      q_resp.push_back('{1'b0, -1});
    end
    @(negedge clk);
    chk("cmp_way", way_o, (hit && rw) ? hway : 3'(p0));
    chk("cmp_index", tag_index_o, idx);
    chk("cmp_tag", tag_cmp_o, tag);
    chk("busy_not_ready", cpu_req_ready_o, 1'b0);
    if (wait_done) begin
      n = 0;
      while (pending() != 0 && n < 300) begin
        // Offer requests while busy; they must not be taken.
        cpu_req_valid_i = !cpu_req_ready_o && ($urandom % 2 == 0);
        cpu_req_addr_i  = $urandom;
        @(negedge clk);
        n++;
      end
      chk("done_timeout", n < 300, 1'b1);
      if (n >= 300) begin
        q_resp.delete();
        q_mem.delete();
        q_tagw.delete();
      end
    end
    cpu_req_valid_i = 1'b0;
  endtask

  task automatic rand_miss(input logic vv, input logic vd);
    txn($urandom, 1'($urandom), 1'b0, 3'd0, vv, vd, 18'($urandom), 1'b1);
  endtask

  initial begin
    int n;
    rst             = 1'b1;
    cpu_req_valid_i = 1'b0;
    cpu_req_rw_i    = 1'b0;
    cpu_req_addr_i  = '0;
    tag_hit_i       = 1'b0;
    tag_hit_way_i   = '0;
    tag_rd_valid_i  = 1'b0;
    tag_rd_dirty_i  = 1'b0;
    tag_rd_tag_i    = '0;
    tag_full_i      = 1'b0;
    #22;
    chk("rst_mem_valid", mem_req_valid_o, 1'b0);
    chk("rst_tag_we", tag_we_o, 1'b0);
    chk("rst_res_valid", cpu_res_valid_o, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", cpu_req_ready_o, 1'b1);
    chk("idle_way", way_o, 3'd0);
    chk("idle_index", tag_index_o, 10'd0);

    // Read miss, invalid victim -> allocate only, way 0, clean.
    txn(32'h0000_1230, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 18'h0, 1'b1);
    // Write hit in way 5.
    txn(32'h0000_1230, 1'b1, 1'b1, 3'd5, 1'b0, 1'b0, 18'h0, 1'b1);
    // Two clean misses bring the pointer to 3.
    rand_miss(1'b1, 1'b0);
    rand_miss(1'b0, 1'b1);
    // Dirty victim tag 0x00ABC at index 0x123 -> writeback then allocate in way 3.
    txn(32'h5555_1230, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 18'h00ABC, 1'b1);
    // Nine allocating misses wrap the pointer.
    for (int i = 0; i < 9; i++) rand_miss(1'b0, 1'b0);

    // Reset while the writeback waits for its ack.
    ack_en = 1'b0;
    txn(32'h1234_5670, 1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 18'h3FFFF, 1'b0);
    n = 0;
    while (!mem_req_valid_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("wb_pending", {mem_req_valid_o, mem_req_rw_o}, 2'b11);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_drop_mem", mem_req_valid_o, 1'b0);
    chk("rst_no_tag_we", tag_we_o, 1'b0);
    q_resp.delete();
    q_mem.delete();
    q_tagw.delete();
    m_ptr  = 0;
    m_hits = 0;
    m_miss = 0;
    ack_en = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", cpu_req_ready_o, 1'b1);
    chk("post_rst_res", cpu_res_valid_o, 1'b0);

    // Three hits and two misses for the statistics counters.
    txn($urandom, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 18'h0, 1'b1);
    rand_miss(1'b1, 1'b1);
    txn($urandom, 1'b1, 1'b1, 3'd7, 1'b1, 1'b1, 18'h0, 1'b1);
    rand_miss(1'b0, 1'b0);
    txn($urandom, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 18'h0, 1'b1);
`ifdef L2_CTRL_STATS_EN
    @(negedge clk);
    chk("stat_hit", stat_hit_o, 32'(m_hits));
    chk("stat_miss", stat_miss_o, 32'(m_miss));
`endif

    // Randomized traffic.
    for (int i = 0; i < 80; i++) begin
      txn($urandom, 1'($urandom), ($urandom % 3 == 0), 3'($urandom),
          1'($urandom), 1'($urandom), 18'($urandom), 1'b1);
    end
    @(negedge clk);
    chk("final_ready", cpu_req_ready_o, 1'b1);
    chk("final_drained", pending(), 0);
`ifdef L2_CTRL_STATS_EN
    chk("final_stat_hit", stat_hit_o, 32'(m_hits));
    chk("final_stat_miss", stat_miss_o, 32'(m_miss));
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "watchdog");
  end

endmodule
